// File: rtl/meter_display_if.sv
// Display-side bus of meter_display: binary count in, seven-segment drive and busy out.
interface meter_display_if;
    logic [15:0] count;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    modport master (output count, input seg, input an, input dp, input busy);
    modport slave  (input count, output seg, output an, output dp, output busy);
endinterface

// File: rtl/meter_display.sv
// Parking-meter display: sequential double-dabble BCD conversion, 4-digit muxed seven-segment drive, low-time blink.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero digits above the ones digit.
module meter_display #(
    parameter int REFRESH_COUNT  = 100000,
    parameter int HALF_SEC_COUNT = 50000000,
    parameter int LOW_THRESHOLD  = 200
) (
    input  logic            clk,
    input  logic            reset,
    meter_display_if.slave  bus
);
    localparam int RW = (REFRESH_COUNT  > 1) ? $clog2(REFRESH_COUNT)  : 1;
    localparam int HW = (HALF_SEC_COUNT > 1) ? $clog2(HALF_SEC_COUNT) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_COUNT - 1);
    localparam logic [HW-1:0] HALF_LAST    = HW'(HALF_SEC_COUNT - 1);
    localparam logic [15:0]   LOW_T        = 16'(LOW_THRESHOLD);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_bin, w_bin_nxt;
    logic [15:0] r_scratch, w_scratch_nxt;
    logic [3:0]  r_iter, w_iter_nxt;
    logic        r_cap_zero, w_cap_zero_nxt;
    logic        r_cap_low, w_cap_low_nxt;
    logic        w_load;
    logic [15:0] r_bcd_q;
    logic        r_zero, r_low;

    logic [15:0] w_sat;
    logic [15:0] w_adj;

    logic [RW-1:0] r_refresh;
    logic [1:0]    r_idx;
    logic [HW-1:0] r_half;
    logic [1:0]    r_phase;

    logic [3:0] w_nib;
    logic [6:0] w_seg;
    logic       w_vis;
    logic       w_lead_zero;
    logic [3:0] r_an;
    logic [6:0] r_seg;

    assign w_sat = (bus.count > 16'd9999) ? 16'd9999 : bus.count;

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin;
        w_scratch_nxt  = r_scratch;
        w_iter_nxt     = r_iter;
        w_cap_zero_nxt = r_cap_zero;
        w_cap_low_nxt  = r_cap_low;
        w_load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bin_nxt      = w_sat;
                w_scratch_nxt  = 16'h0000;
                w_iter_nxt     = 4'd0;
                w_cap_zero_nxt = (w_sat == 16'd0);
                w_cap_low_nxt  = (w_sat != 16'd0) && (w_sat < LOW_T);
                w_state_nxt    = S_SHIFT;
            end
            S_SHIFT: begin
                {w_scratch_nxt, w_bin_nxt} = {w_adj[14:0], r_bin, 1'b0};
                w_iter_nxt = r_iter + 4'd1;
                if (r_iter == 4'd15)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_load      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bin      <= 16'h0000;
            r_scratch  <= 16'h0000;
            r_iter     <= 4'd0;
            r_cap_zero <= 1'b0;
            r_cap_low  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bin      <= w_bin_nxt;
            r_scratch  <= w_scratch_nxt;
            r_iter     <= w_iter_nxt;
            r_cap_zero <= w_cap_zero_nxt;
            r_cap_low  <= w_cap_low_nxt;
        end
    end

    // Blink status travels with the value it was computed from, so digits and blink never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd_q <= 16'h0000;
            r_zero  <= 1'b0;
            r_low   <= 1'b0;
        end else if (w_load) begin
            r_bcd_q <= r_scratch;
            r_zero  <= r_cap_zero;
            r_low   <= r_cap_low;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_half  <= '0;
            r_phase <= 2'd0;
        end else if (r_half == HALF_LAST) begin
            r_half  <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_half  <= r_half + 1'b1;
        end
    end

    assign w_nib = r_bcd_q[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'd0: w_seg = 7'h40;
            4'd1: w_seg = 7'h79;
            4'd2: w_seg = 7'h24;
            4'd3: w_seg = 7'h30;
            4'd4: w_seg = 7'h19;
            4'd5: w_seg = 7'h12;
            4'd6: w_seg = 7'h02;
            4'd7: w_seg = 7'h78;
            4'd8: w_seg = 7'h00;
            4'd9: w_seg = 7'h10;
            default: w_seg = 7'h7F;
        endcase
    end

    always_comb begin
        w_vis = 1'b1;
        if (r_zero)
            w_vis = ~r_phase[0];
        else if (r_low)
            w_vis = ~r_phase[1];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero; the ones digit always shows.
    always_comb begin
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd1: w_lead_zero = (r_bcd_q[15:4]  == 12'h000);
            2'd2: w_lead_zero = (r_bcd_q[15:8]  == 8'h00);
            2'd3: w_lead_zero = (r_bcd_q[15:12] == 4'h0);
            default: w_lead_zero = 1'b0;
        endcase
    end
`else
    assign w_lead_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else if (!w_vis) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_lead_zero ? 7'h7F : w_seg;
        end
    end

    assign bus.an   = r_an;
    assign bus.seg  = r_seg;
    assign bus.dp   = 1'b1;
    assign bus.busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_meter_display.sv
// Self-checking bench for meter_display: vector table, randomized counts against an arithmetic display model, corner sequences.
module tb_meter_display;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ncyc = 0;
    int   total = 0;
    int   bad = 0;

    meter_display_if mif();

    meter_display #(.REFRESH_COUNT(4), .HALF_SEC_COUNT(16), .LOW_THRESHOLD(200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    // Non-reset rising edges since the last reset; the display schedule is a pure function of this.
    always @(posedge clk) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] bcd;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int s;
        s = sat(v);
        r[15:12] = 4'((s / 1000) % 10);
        r[11:8]  = 4'((s / 100) % 10);
        r[7:4]   = 4'((s / 10) % 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] lut [10];
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return lut[d];
    endfunction

    // Expected {an,seg} for saturated value v, with m = rising edges since reset feeding the output register.
    function automatic logic [10:0] model_disp(input int v, input int m);
        int idx, ph, p10, dig;
        bit vis;
        logic [3:0] an;
        logic [6:0] sg;
        idx = (m / 4) % 4;
        ph  = (m / 16) % 4;
        if (v == 0)        vis = (ph % 2) == 0;
        else if (v < 200)  vis = ph < 2;
        else               vis = 1'b1;
        if (!vis) return {4'b1111, 7'h7F};
        p10 = 1;
        for (int k = 0; k < idx; k++) p10 = p10 * 10;
        dig = (v / p10) % 10;
        an = 4'b1111;
        an[idx] = 1'b0;
        sg = seg_of(dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p10) sg = 7'h7F;
`endif
        return {an, sg};
    endfunction

    task automatic wait_bcd(input logic [15:0] exp, input string name);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (dut.r_bcd_q === exp) break;
        end
        chk(name, 32'(dut.r_bcd_q), 32'(exp));
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.busy === lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(name, 32'(mif.busy), 32'(lvl));
    endtask

    task automatic check_display(input int v, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(name, {21'd0, mif.an, mif.seg}, {21'd0, model_disp(v, ncyc - 1)});
        end
        chk({name, "_dp"}, 32'(mif.dp), 32'd1);
    endtask

    initial begin
        int v, bucket;

        vt[0] = '{16'd1234,  16'h1234};
        vt[1] = '{16'd12000, 16'h9999};
        vt[2] = '{16'd150,   16'h0150};
        vt[3] = '{16'd0,     16'h0000};
        vt[4] = '{16'd9999,  16'h9999};
        vt[5] = '{16'd10000, 16'h9999};
        vt[6] = '{16'd199,   16'h0199};
        vt[7] = '{16'd200,   16'h0200};
        vt[8] = '{16'd42,    16'h0042};
        vt[9] = '{16'd1,     16'h0001};

        mif.count = 16'd1234;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_an",   32'(mif.an),   32'hF);
            chk("rst_seg",  32'(mif.seg),  32'h7F);
            chk("rst_busy", 32'(mif.busy), 32'h0);
            chk("rst_dp",   32'(mif.dp),   32'h1);
        end
        chk("rst_bcd", 32'(dut.r_bcd_q), 32'h0);
        reset = 1'b0;
        wait_bcd(16'h1234, "bcd_after_rst");
        check_display(1234, 32, "disp_1234");

        for (int i = 0; i < 10; i++) begin
            mif.count = vt[i].cnt;
            wait_bcd(vt[i].bcd, $sformatf("vec%0d_bcd", i));
            check_display(sat(int'(vt[i].cnt)), 64, $sformatf("vec%0d_disp", i));
        end

        // A count change mid-conversion must not leak into that conversion.
        mif.count = 16'd777;
        wait_bcd(16'h0777, "pre_777");
        wait_busy(1'b0, "idle_wait_a");
        mif.count = 16'd300;
        wait_busy(1'b1, "shift_wait_a");
        mif.count = 16'd250;
        wait_busy(1'b0, "done_wait_a");
        chk("mid_shift_300", 32'(dut.r_bcd_q), 32'h0300);
        wait_busy(1'b1, "shift_wait_b");
        wait_busy(1'b0, "done_wait_b");
        chk("next_conv_250", 32'(dut.r_bcd_q), 32'h0250);

        // Reset in the 8th SHIFT cycle aborts the conversion.
        mif.count = 16'd5;
        wait_bcd(16'h0005, "pre_5");
        wait_busy(1'b0, "idle_wait_c");
        mif.count = 16'd7;
        wait_busy(1'b1, "shift_wait_c");
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_bcd",  32'(dut.r_bcd_q), 32'h0);
        chk("abort_busy", 32'(mif.busy),    32'h0);
        chk("abort_an",   32'(mif.an),      32'hF);
        chk("abort_seg",  32'(mif.seg),     32'h7F);
        reset = 1'b0;
        wait_bcd(16'h0007, "after_abort_7");
        check_display(7, 40, "disp_7");

        for (int i = 0; i < 24; i++) begin
            bucket = int'($urandom_range(0, 3));
            case (bucket)
                0:       v = 0;
                1:       v = int'($urandom_range(1, 199));
                2:       v = int'($urandom_range(200, 9999));
                default: v = int'($urandom_range(10000, 65535));
            endcase
            mif.count = 16'(v);
            wait_bcd(to_bcd(v), $sformatf("rnd%0d_bcd_v%0d", i, v));
            check_display(sat(v), 40, $sformatf("rnd%0d_disp_v%0d", i, v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
